lane_training_tx_ctrl: RTL

// - Upstream sequencer for data_bus_transmit: drives d_sel through the USB4 lane-training ordered-set phases.
// - Gen3 path: SLOS1 -> SLOS2 -> TS1 -> TS2 -> CL0. Gen4 path: TS1 -> TS2 -> TS3 -> TS4 -> CL0.
// - Advances on os_sent pulses from data_bus_transmit plus partner progress from the receive side.
// - Holds CL0 (transport data, d_sel=8) until disconnect; abandons training on per-phase timeout.

---
 rtl/lt_pkg.sv | 68 ++++++
 rtl/lt_phase_timer.sv | 41 ++++
 rtl/lane_training_tx_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lt_pkg.sv
// -----------------------------------------------------------------------------
// lt_pkg
// Shared definitions for the USB4 lane-training transmit sequencer:
//   - lt_state_e : training FSM states
//   - D_SEL_*    : phase-select codes understood by data_bus_transmit
//   - d_sel_of   : state -> phase-select code
//   - next_phase : ordered-set phase that follows a given training phase
// -----------------------------------------------------------------------------
package lt_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SLOS1  = 4'd1,
    SLOS2  = 4'd2,
    G3_TS1 = 4'd3,
    G3_TS2 = 4'd4,
    G4_TS1 = 4'd5,
    G4_TS2 = 4'd6,
    G4_TS3 = 4'd7,
    G4_TS4 = 4'd8,
    CL0    = 4'd9
  } lt_state_e;

  localparam logic [3:0] D_SEL_SLOS1  = 4'd0;
  localparam logic [3:0] D_SEL_SLOS2  = 4'd1;
  localparam logic [3:0] D_SEL_G3_TS1 = 4'd2;
  localparam logic [3:0] D_SEL_G3_TS2 = 4'd3;
  localparam logic [3:0] D_SEL_G4_TS1 = 4'd4;
  localparam logic [3:0] D_SEL_G4_TS2 = 4'd5;
  localparam logic [3:0] D_SEL_G4_TS3 = 4'd6;
  localparam logic [3:0] D_SEL_G4_TS4 = 4'd7;
  localparam logic [3:0] D_SEL_CL0    = 4'd8;
  localparam logic [3:0] D_SEL_IDLE   = 4'd9;

  function automatic logic [3:0] d_sel_of(input lt_state_e st);
    logic [3:0] sel;
    case (st)
      SLOS1:   sel = D_SEL_SLOS1;
      SLOS2:   sel = D_SEL_SLOS2;
      G3_TS1:  sel = D_SEL_G3_TS1;
      G3_TS2:  sel = D_SEL_G3_TS2;
      G4_TS1:  sel = D_SEL_G4_TS1;
      G4_TS2:  sel = D_SEL_G4_TS2;
      G4_TS3:  sel = D_SEL_G4_TS3;
      G4_TS4:  sel = D_SEL_G4_TS4;
      CL0:     sel = D_SEL_CL0;
      default: sel = D_SEL_IDLE;
    endcase
    return sel;
  endfunction

  function automatic lt_state_e next_phase(input lt_state_e st);
    lt_state_e nxt;
    case (st)
      SLOS1:   nxt = SLOS2;
      SLOS2:   nxt = G3_TS1;
      G3_TS1:  nxt = G3_TS2;
      G3_TS2:  nxt = CL0;
      G4_TS1:  nxt = G4_TS2;
      G4_TS2:  nxt = G4_TS3;
      G4_TS3:  nxt = G4_TS4;
      G4_TS4:  nxt = CL0;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lt_phase_timer.sv
// -----------------------------------------------------------------------------
// lt_phase_timer
// Per-phase watchdog. Counts cycles while enabled; clear has priority and
// returns the count to zero. expire is high during the last allowed cycle
// (count == TIMEOUT-1) so the owner can leave the phase on the next edge.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous reset, active-low
//   clear  in  zero the counter this edge
//   enable in  count this cycle
//   expire out phase budget used up (combinational from the count register)
// -----------------------------------------------------------------------------
module lt_phase_timer #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] count_r;

  // Cycle counter for the current phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = enable && (count_r == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/lane_training_tx_ctrl.sv
// -----------------------------------------------------------------------------
// lane_training_tx_ctrl
// Steps data_bus_transmit through the USB4 lane-training ordered-set phases
// (Gen3: SLOS1, SLOS2, TS1, TS2; Gen4: TS1..TS4) and then holds CL0.
// A phase advances only on an os_sent pulse, once enough ordered sets have
// gone out and the receive side reports the partner in the same phase.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_training  pulse, starts training from IDLE
//   gen4_sel        path select sampled with start_training
//   disconnect      level, back to IDLE from anywhere (no error)
//   os_sent         pulse at each ordered-set boundary
//   tx_lanes_on     lanes are driving (gates SLOS1 exit)
//   rx_phase_ok     partner ordered sets of current phase detected
//   d_sel           registered phase select
//   training_done   high while in CL0
//   training_error  one-cycle pulse when a phase times out
//   os_cnt_o        saturating ordered-set count in current phase
// -----------------------------------------------------------------------------
module lane_training_tx_ctrl
  import lt_pkg::*;
#(
  parameter int SLOS_MIN = 2,
  parameter int TS_MIN   = 16,
  parameter int TIMEOUT  = 4096,
  parameter int TO_W     = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_training,
  input  logic       gen4_sel,
  input  logic       disconnect,
  input  logic       os_sent,
  input  logic       tx_lanes_on,
  input  logic       rx_phase_ok,
  output logic [3:0] d_sel,
  output logic       training_done,
  output logic       training_error,
  output logic [4:0] os_cnt_o
);

  lt_state_e  state_r;
  logic       gen4_r;
  logic [4:0] os_cnt_r;

  logic       in_training_s;
  logic       slos_phase_s;
  logic       lanes_ok_s;
  logic [5:0] cnt_next_s;
  logic [5:0] min_s;
  logic       adv_s;
  logic       expire_s;
  logic       timer_clear_s;
  lt_state_e  adv_state_s;

  // Advance qualification for the current phase; count is widened so the
  // saturated value 31 still compares correctly as 32.
  always_comb begin
    in_training_s = (state_r != IDLE) && (state_r != CL0);
    slos_phase_s  = !gen4_r && ((state_r == SLOS1) || (state_r == SLOS2));
    lanes_ok_s    = (state_r == SLOS1) ? tx_lanes_on : 1'b1;
    cnt_next_s    = {1'b0, os_cnt_r} + 6'd1;
    min_s         = slos_phase_s ? 6'(SLOS_MIN) : 6'(TS_MIN);
    adv_s         = in_training_s && os_sent && rx_phase_ok && lanes_ok_s &&
                    (cnt_next_s >= min_s);
    adv_state_s   = next_phase(state_r);
    // Timer restarts on any phase change and idles outside training.
    timer_clear_s = !in_training_s || disconnect || expire_s || adv_s;
  end

  lt_phase_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (in_training_s),
    .expire (expire_s)
  );

  // Training FSM with registered outputs: disconnect > timeout > advance > count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      gen4_r         <= 1'b0;
      os_cnt_r       <= 5'd0;
      d_sel          <= D_SEL_IDLE;
      training_done  <= 1'b0;
      training_error <= 1'b0;
    end else begin
      training_error <= 1'b0;
      if (disconnect) begin
        state_r       <= IDLE;
        os_cnt_r      <= 5'd0;
        d_sel         <= D_SEL_IDLE;
        training_done <= 1'b0;
      end else if (expire_s) begin
        state_r        <= IDLE;
        os_cnt_r       <= 5'd0;
        d_sel          <= D_SEL_IDLE;
        training_done  <= 1'b0;
        training_error <= 1'b1;
      end else if ((state_r == IDLE) && start_training) begin
        gen4_r        <= gen4_sel;
        state_r       <= gen4_sel ? G4_TS1 : SLOS1;
        os_cnt_r      <= 5'd0;
        d_sel         <= gen4_sel ? D_SEL_G4_TS1 : D_SEL_SLOS1;
        training_done <= 1'b0;
      end else if (adv_s) begin
        state_r       <= adv_state_s;
        os_cnt_r      <= 5'd0;
        d_sel         <= d_sel_of(adv_state_s);
        training_done <= (adv_state_s == CL0);
      end else if (os_sent && (os_cnt_r != 5'd31)) begin
        os_cnt_r <= os_cnt_r + 5'd1;
      end else begin
        os_cnt_r <= os_cnt_r;
      end
    end
  end

  assign os_cnt_o = os_cnt_r;

endmodule
